vend_panel: RTL

VEND_PANEL -- requirements
Module: vend_panel

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_debounce.sv | 60 ++++++
 rtl/vend_panel.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and default timing constants for the vending front-panel block.
package vend_pkg;

   typedef logic [7:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_VEND      = 2'd1,
      ST_WAIT_TAKE = 2'd2
   } vend_state_e;

   localparam int DEB_CYC_DEF    = 16;
   localparam int MOTOR_CYC_DEF  = 32;
   localparam int HOPPER_CYC_DEF = 16;
   localparam int FLASH_CYC_DEF  = 8;

   // Saturating decrement: counters rest at zero instead of wrapping.
   function automatic cnt_t dec_sat(input cnt_t v);
      if (v == 8'd0) begin
         return 8'd0;
      end else begin
         return v - 8'd1;
      end
   endfunction

endpackage

// File: rtl/vend_debounce.sv
// One raw contact: 2-flop synchronizer, counting debouncer and a registered
// rising-edge pulse of the debounced level.
module vend_debounce
   import vend_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw_i,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic level_q;
   logic level_d;
   logic rise_q;
   logic rise_d;
   cnt_t cnt_q;
   cnt_t cnt_d;

   // The level only flips once the synchronized input has disagreed for DEB_CYC samples.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = 8'd0;
      if (sync2_q != level_q) begin
         if (cnt_q == 8'(DEB_CYC - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = 8'd0;
         end else begin
            cnt_d   = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = 8'd0;
      end
   end

   // Synchronizer, debounce counter and stable level registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/vend_panel.sv
// Vending front panel: debounced contacts become prioritised single-cycle events,
// controller levels drive motor, hopper and lamp timers.
module vend_panel
   import vend_pkg::*;
#(
   parameter int DEB_CYC    = DEB_CYC_DEF,
   parameter int MOTOR_CYC  = MOTOR_CYC_DEF,
   parameter int HOPPER_CYC = HOPPER_CYC_DEF,
   parameter int FLASH_CYC  = FLASH_CYC_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic coin_sw,
   input  logic cancel_btn,
   input  logic select_btn,
   input  logic door_sw,
   input  logic flash,
   input  logic drink,
   input  logic change,
   output logic coin,
   output logic cancel,
   output logic selection,
   output logic received,
   output logic lamp_flash,
   output logic motor_on,
   output logic hopper_on,
   output logic busy
);

   logic        coin_rise_s;
   logic        cancel_rise_s;
   logic        select_rise_s;
   logic        door_rise_s;
   logic        rcv_rise_s;
   logic        flash_rise_s;
   logic        drink_rise_s;
   logic        change_rise_s;
   logic [3:0]  rise_s;
   logic [3:0]  grant_s;
   logic [3:0]  pend_q;
   logic [3:0]  pend_d;
   logic [3:0]  pulse_q;
   logic        flash_q;
   logic        drink_q;
   logic        change_q;
   vend_state_e state_q;
   vend_state_e state_d;
   cnt_t        mcnt_q;
   cnt_t        mcnt_d;
   cnt_t        hcnt_q;
   cnt_t        hcnt_d;
   cnt_t        fcnt_q;
   cnt_t        fcnt_d;
   logic        motor_q;
   logic        hopper_q;
   logic        hopper_d;
   logic        lamp_q;
   logic        busy_q;

   vend_debounce #(.DEB_CYC(DEB_CYC)) u_deb_coin   (.clk(clk), .resetn(resetn), .raw_i(coin_sw),    .rise_o(coin_rise_s));
   vend_debounce #(.DEB_CYC(DEB_CYC)) u_deb_cancel (.clk(clk), .resetn(resetn), .raw_i(cancel_btn), .rise_o(cancel_rise_s));
   vend_debounce #(.DEB_CYC(DEB_CYC)) u_deb_select (.clk(clk), .resetn(resetn), .raw_i(select_btn), .rise_o(select_rise_s));
   vend_debounce #(.DEB_CYC(DEB_CYC)) u_deb_door   (.clk(clk), .resetn(resetn), .raw_i(door_sw),    .rise_o(door_rise_s));

   assign flash_rise_s  = flash  & ~flash_q;
   assign drink_rise_s  = drink  & ~drink_q;
   assign change_rise_s = change & ~change_q;

   // Actuator FSM; a door edge only counts as a pickup once the drink has dropped.
   always_comb begin
      state_d    = state_q;
      mcnt_d     = mcnt_q;
      rcv_rise_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drink_rise_s) begin
               state_d = ST_VEND;
               mcnt_d  = 8'(MOTOR_CYC);
            end else begin
               mcnt_d  = 8'd0;
            end
         end
         ST_VEND: begin
            if (mcnt_q <= 8'd1) begin
               state_d = ST_WAIT_TAKE;
               mcnt_d  = 8'd0;
            end else begin
               mcnt_d  = dec_sat(mcnt_q);
            end
         end
         ST_WAIT_TAKE: begin
            if (door_rise_s) begin
               rcv_rise_s = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d    = ST_WAIT_TAKE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            mcnt_d  = 8'd0;
         end
      endcase
   end

   // Hopper ignores new requests mid-payout; the lamp timer restarts on every edge.
   always_comb begin
      hcnt_d = dec_sat(hcnt_q);
      fcnt_d = dec_sat(fcnt_q);
      if (change_rise_s && !hopper_q) begin
         hcnt_d = 8'(HOPPER_CYC);
      end else begin
         hcnt_d = dec_sat(hcnt_q);
      end
      if (flash_rise_s) begin
         fcnt_d = 8'(FLASH_CYC);
      end else begin
         fcnt_d = dec_sat(fcnt_q);
      end
      hopper_d = (hcnt_d != 8'd0);
   end

   // Fixed-priority arbiter over one-deep pending flags: cancel > coin > selection > received.
   always_comb begin
      rise_s  = {rcv_rise_s, select_rise_s, coin_rise_s, cancel_rise_s};
      grant_s = 4'b0000;
      if (pend_q[0]) begin
         grant_s = 4'b0001;
      end else if (pend_q[1]) begin
         grant_s = 4'b0010;
      end else if (pend_q[2]) begin
         grant_s = 4'b0100;
      end else if (pend_q[3]) begin
         grant_s = 4'b1000;
      end else begin
         grant_s = 4'b0000;
      end
      pend_d = (pend_q & ~grant_s) | rise_s;
   end

   // All state and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         mcnt_q   <= 8'd0;
         hcnt_q   <= 8'd0;
         fcnt_q   <= 8'd0;
         pend_q   <= 4'b0000;
         pulse_q  <= 4'b0000;
         flash_q  <= 1'b0;
         drink_q  <= 1'b0;
         change_q <= 1'b0;
         motor_q  <= 1'b0;
         hopper_q <= 1'b0;
         lamp_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcnt_q   <= mcnt_d;
         hcnt_q   <= hcnt_d;
         fcnt_q   <= fcnt_d;
         pend_q   <= pend_d;
         pulse_q  <= grant_s;
         flash_q  <= flash;
         drink_q  <= drink;
         change_q <= change;
         motor_q  <= (state_d == ST_VEND);
         hopper_q <= hopper_d;
         lamp_q   <= (fcnt_d != 8'd0);
         busy_q   <= (state_d != ST_IDLE) || hopper_d;
      end
   end

   assign cancel     = pulse_q[0];
   assign coin       = pulse_q[1];
   assign selection  = pulse_q[2];
   assign received   = pulse_q[3];
   assign motor_on   = motor_q;
   assign hopper_on  = hopper_q;
   assign lamp_flash = lamp_q;
   assign busy       = busy_q;

endmodule
